cla16_pipe_adder: RTL
=====================

Name: cla16_pipe_adder

Overview:
Two-stage pipelined 16-bit carry-lookahead adder with valid/ready handshakes on input and output.
- Stage 1 registers the operands and derives per-bit propagate/generate, then the 4-bit group P/G vectors.
- Stage 2 forms the group carries c4/c8/c12/c16 by two-level lookahead, then registers the sum and carry-out.
- Serves as the ALU add path wherever a registered, back-pressurable 16-bit add is needed.

Parameters:
- WIDTH, 16, operand width. Only 16 is legal; an elaboration-time check errors on any other value.
- GROUP, 4, bits per lookahead group. Only 4 is legal; WIDTH/GROUP = 4 groups.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  16  operand A
- b  input  16  operand B
- cin  input  1  carry-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  16  registered a+b+cin, low 16 bits
- cout  output  1  registered carry out of bit 15 (c16)

Behaviour:
Clock, reset and handshakes:
- One clock. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: s1_valid=0, out_valid=0, sum=0, cout=0. Stage-1 data regs also reset to 0.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- out_adv = !out_valid || out_ready.
- s1_adv = !s1_valid || out_adv.
- in_ready = s1_adv (combinational from registered state and out_ready; no combinational path from in_valid).

Stage 1 (on s1_adv):
- s1_valid <= in_valid.
- On input transfer, capture a, b, cin, bit p=a^b, g=a&b, and group Pk=&p[4k+3:4k], Gk (4-bit lookahead form), k=0..3.

Stage 2 (on out_adv):
- out_valid <= s1_valid.
- If s1_valid, register the results:
  - c4 = G0|P0&cin
  - c8, c12, c16 by full two-level expansion, no ripple between groups.
  - Intra-group carries by 4-bit lookahead from the group carry-in.
  - sum = p ^ carries; cout = c16.

Timing and throughput:
- Latency: input transfer in cycle N produces out_valid in cycle N+2.
- Throughput: 1 result/cycle while out_ready=1.

Stalls and ordering:
- While out_valid && !out_ready, sum/cout/out_valid hold stable.
- Stage 1 holds while full and blocked; in_ready=0 only when both stages are full and out_ready=0.
- Simultaneous output transfer and new stage-1 data in the same cycle: the output reloads with no bubble.
- No reordering or dropping. Every accepted operand pair yields exactly one result, in order.
- Data registers do not change when no transfer occurs (X-free when idle after reset).

Reset mid-operation:
- Flushes both stages. The results of in-flight operands are discarded and never presented.

Arithmetic:
- Modulo 2^16 with carry. 16'hFFFF + 16'h0001 + 0 gives sum=16'h0000, cout=1.

Optional Feature:
- Macro CLA16_OVERFLOW_EN.
- When defined: extra output port ovf (1 bit) = c16 ^ c15, the two's-complement signed overflow. It is registered alongside sum, resets to 0 and holds under stall.
- When undefined: the port is absent and no extra logic is generated.

Decomposition:
- Shared package cla_pkg holds:
  - constants CLA_WIDTH=16, CLA_GROUP=4, CLA_NGROUPS=4
  - typedef grp_pg_t, a struct {logic [3:0] P; logic [3:0] G;}
- One sub-module is natural: cla_group4. It is combinational and takes p[3:0], g[3:0] and a group cin. It returns group P, group G and internal carries c[3:1].
  - Instantiated 4x for group P/G in stage 1.
  - Instantiated 4x for intra-group carries in stage 2.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0; in_ready=1 after release.
2. Single op: a=16'h1234, b=16'h4321, cin=0 in cycle N -> cycle N+2 out_valid=1, sum=16'h5555, cout=0.
3. Full carry chain: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. With the macro defined, a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, ovf=1.
4. Back-pressure: stream 4 ops with out_ready=0 -> in_ready drops after the 2nd accept and sum holds the 1st result. Raise out_ready -> results emerge in order, one per cycle, none lost or duplicated.
5. Mid-flight reset: accept 2 ops, assert rst_n=0 for 1 cycle -> neither result ever appears and out_valid=0 the following cycle.
6. Random: 10k random a/b/cin with random out_ready -> every result equals a+b+cin against a scoreboard, in order.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants, group propagate/generate type and the two-level group-carry
// lookahead used by the pipelined 16-bit carry-lookahead adder.
package cla_pkg;

    localparam int CLA_WIDTH   = 16;
    localparam int CLA_GROUP   = 4;
    localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

    typedef struct packed {
        logic [3:0] P;
        logic [3:0] G;
    } grp_pg_t;

    // Returns {c16, c12, c8, c4}; each term is fully expanded so no group waits on another.
    function automatic logic [3:0] group_carries(grp_pg_t pg, logic ci);
        logic [3:0] c;
        c[0] = pg.G[0]
             | (pg.P[0] & ci);
        c[1] = pg.G[1]
             | (pg.P[1] & pg.G[0])
             | (pg.P[1] & pg.P[0] & ci);
        c[2] = pg.G[2]
             | (pg.P[2] & pg.G[1])
             | (pg.P[2] & pg.P[1] & pg.G[0])
             | (pg.P[2] & pg.P[1] & pg.P[0] & ci);
        c[3] = pg.G[3]
             | (pg.P[3] & pg.G[2])
             | (pg.P[3] & pg.P[2] & pg.G[1])
             | (pg.P[3] & pg.P[2] & pg.P[1] & pg.G[0])
             | (pg.P[3] & pg.P[2] & pg.P[1] & pg.P[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/cla16_pipe_adder_group4.sv
// cla_group4: combinational 4-bit lookahead cell producing group P/G and the
// three internal carries from a group carry-in.
module cla_group4
    import cla_pkg::*;
(
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic       gp,
    output logic       gg,
    output logic [3:1] c
);

    always_comb begin
        gp   = &p;
        gg   = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    end

endmodule

// File: rtl/cla16_pipe_adder.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready on both sides.
// Define CLA16_OVERFLOW_EN to add the registered signed-overflow output ovf.
module cla16_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA16_OVERFLOW_EN
    ,output logic            ovf
`endif
);

    if (WIDTH != CLA_WIDTH || GROUP != CLA_GROUP) begin : g_bad_param
        $error("cla16_pipe_adder supports only WIDTH=16, GROUP=4");
    end

    logic             out_adv;
    logic             s1_adv;

    logic             s1_valid_q, s1_valid_d;
    logic             cin_q,      cin_d;
    logic [WIDTH-1:0] p_q,        p_d;
    logic [WIDTH-1:0] g_q,        g_d;
    grp_pg_t          grp_q,      grp_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
`ifdef CLA16_OVERFLOW_EN
    logic             ovf_q,       ovf_d;
`endif

    logic [WIDTH-1:0] bit_p, bit_g;
    logic [3:0]       grp_p_s1, grp_g_s1;
    logic [3:0][3:1]  unused_s1_c;

    logic [3:0]       grp_c;
    logic [3:0]       grp_cin;
    logic [3:0][3:1]  intra_c;
    logic [3:0]       unused_s2_p, unused_s2_g;
    logic [WIDTH-1:0] carry;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    for (genvar k = 0; k < CLA_NGROUPS; k++) begin : g_s1
        cla_group4 u_pg (
            .p  (bit_p[k*CLA_GROUP +: CLA_GROUP]),
            .g  (bit_g[k*CLA_GROUP +: CLA_GROUP]),
            .ci (1'b0),
            .gp (grp_p_s1[k]),
            .gg (grp_g_s1[k]),
            .c  (unused_s1_c[k])
        );
    end

    // Group carries depend only on registered group P/G, never on each other.
    assign grp_c   = group_carries(grp_q, cin_q);
    assign grp_cin = {grp_c[2:0], cin_q};

    for (genvar k = 0; k < CLA_NGROUPS; k++) begin : g_s2
        cla_group4 u_carry (
            .p  (p_q[k*CLA_GROUP +: CLA_GROUP]),
            .g  (g_q[k*CLA_GROUP +: CLA_GROUP]),
            .ci (grp_cin[k]),
            .gp (unused_s2_p[k]),
            .gg (unused_s2_g[k]),
            .c  (intra_c[k])
        );
    end

    always_comb begin
        carry = '0;
        for (int k = 0; k < CLA_NGROUPS; k++) begin
            carry[k*CLA_GROUP]                   = grp_cin[k];
            carry[k*CLA_GROUP+1 +: CLA_GROUP-1]  = intra_c[k];
        end
    end

    assign out_adv  = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || out_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        cin_d      = cin_q;
        p_d        = p_q;
        g_d        = g_q;
        grp_d      = grp_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                cin_d   = cin;
                p_d     = bit_p;
                g_d     = bit_g;
                grp_d.P = grp_p_s1;
                grp_d.G = grp_g_s1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
`ifdef CLA16_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif
        if (out_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = p_q ^ carry;
                cout_d = grp_c[3];
`ifdef CLA16_OVERFLOW_EN
                ovf_d  = grp_c[3] ^ carry[WIDTH-1];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            cin_q       <= 1'b0;
            p_q         <= '0;
            g_q         <= '0;
            grp_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef CLA16_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            cin_q       <= cin_d;
            p_q         <= p_d;
            g_q         <= g_d;
            grp_q       <= grp_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
`ifdef CLA16_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA16_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule
